placement_reader: RTL and testbench
===================================

# placement_reader

Read-back engine for the placement result memories. After the placer finishes, this block scans the grid RAM cell by cell in row-major order. For each occupied cell it fetches the node's pos_X/pos_Y entries and checks that they agree with the cell coordinates. It then streams (node, x, y) tuples out over a valid/ready interface. It sits beside the placer on the same grid and position RAMs and serves as the export and consistency-check path for the placement.

## Interface
- N, 7, grid side; grid holds N*N cells, address = x*N + y
- N_NODES, 128, position RAM depth (2^tam_pos_mem)
- EMPTY, -1, grid sentinel for a free cell
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; begins a scan when idle
- busy  out  1  high while a scan is in progress
- done  out  1  one-cycle pulse when the scan completes
- grid_rd  out  1  grid read strobe
- grid_addr  out  32  grid cell address
- grid_rdata  in  32 signed  grid word (node id or EMPTY)
- pos_rd  out  1  read strobe, shared by pos_X and pos_Y
- pos_addr  out  32  node id
- posx_rdata, posy_rdata  in  32 signed  stored X/Y position of the node
- out_valid  out  1  tuple available
- out_ready  in  1  consumer accepts
- out_node, out_x, out_y  out  32  tuple payload
- out_err  out  1  the current tuple failed the consistency check
- placed_count  out  32  occupied cells found in the current/last scan
- error  out  1  sticky; any mismatch or bad id in the last scan
- err_cell  out  32  address of the first failing cell

## Operation
- States:
  - IDLE: wait for start.
  - GRID_RD: assert grid_rd, grid_addr = cell.
  - GRID_WAIT: wait for grid data.
  - CLASSIFY
  - POS_RD: assert pos_rd, pos_addr = node.
  - POS_WAIT: wait for position data.
  - CHECK
  - EMIT
  - ADVANCE
  - FIN
- IDLE: on start, clear placed_count, error and err_cell; set cell=0, row=0, col=0; go to GRID_RD.
- Cell coordinates come from row/col counters (x=row, y=col). No divider. col wraps at N-1 and increments row.
- CLASSIFY:
  - grid_rdata == EMPTY: go to ADVANCE.
  - grid_rdata < 0 or >= N_NODES: this is a bad id. Set error; latch err_cell if this is the first error. Emit the tuple with out_err=1 and x=row, y=col. Skip the position read.
  - Otherwise: latch node, increment placed_count, go to POS_RD.
- CHECK: out_err = (posx_rdata != row) || (posy_rdata != col). On mismatch, set error and latch err_cell if it is the first error. The payload always carries the grid coordinates.
- EMIT: hold out_valid with stable payload until out_ready; the transfer completes in that cycle. Go to ADVANCE.
- ADVANCE: if cell == N*N-1, go to FIN; otherwise step the counters and go to GRID_RD.
- FIN: pulse done for one cycle, then go to IDLE. Status outputs hold until the next start.
- start while busy is ignored.

## Timing
- Memories: a strobe in cycle t returns data in t+1. GRID_WAIT and POS_WAIT are one cycle each.
- Cost per cell:
  - Empty cell: 4 cycles (GRID_RD, GRID_WAIT, CLASSIFY, ADVANCE).
  - Occupied cell with out_ready already high: 8 cycles.
  - Each stalled cycle in EMIT adds 1.
- Scan latency:
  - Empty N=7 grid: start to done = 1 + 49*4 + 1 cycles.
  - busy rises the cycle after start and falls with the done cycle.
- Reset values:
  - All strobes, out_valid, busy, done, out_err, error: 0.
  - Addresses, payload, placed_count, err_cell: 0.
  - State: IDLE.
- Reset mid-scan: immediate return to IDLE with all outputs at their reset values; the partial scan is discarded.
- out_valid is never deasserted without a handshake. The payload must not change while out_valid=1 and out_ready=0.
- Strobes are registered single-cycle pulses. Memory control signals have no combinational paths from inputs.

## Structure
- The shared placement package holds:
  - N, N_NODES, EMPTY
  - the state enum encoding
  - the tuple struct (node, x, y, err)
- The memoryRAM instances stay in the top level. This block exposes the read ports only; arbitration with the placer is done at top level via busy.
- Natural sub-module: placement_tuple_skid, a one-entry output register with valid/ready hold. Everything else stays in one FSM.

## Test plan
- All cells EMPTY, start → 49 grid reads, no out_valid, placed_count=0, error=0, done 198 cycles after start.
- grid[10]=5, posX[5]=1, posY[5]=3, rest empty → exactly one beat {node 5, x 1, y 3, out_err 0}, placed_count=1.
- Same setup with out_ready low for 5 cycles → out_valid held and payload constant for 5 cycles; the beat transfers on the first ready cycle.
- grid[10]=5, posX[5]=2 → beat with out_err=1, error=1, err_cell=10. A later mismatch at cell 20 leaves err_cell at 10.
- grid[3]=200 (≥ N_NODES) → no pos_rd issued, beat {200, 0, 3, err 1}, error=1.
- Full grid, cell c holding node c, positions consistent → 49 beats in cell order. Assert reset during beat 20 → busy=0 and out_valid=0 immediately; a new start rescans from cell 0.

Source files
------------

// File: rtl/placement_reader_pkg.sv
// Shared placement constants, read-back FSM encoding and the tuple bundle
// streamed by placement_reader.
package placement_reader_pkg;

   localparam int N     = 7;
   localparam int CELLS = N * N;

   localparam logic signed [31:0] N_NODES = 32'sd128;
   localparam logic signed [31:0] EMPTY   = -32'sd1;

   typedef enum logic [3:0] {
      IDLE,
      GRID_RD,
      GRID_WAIT,
      CLASSIFY,
      POS_RD,
      POS_WAIT,
      CHECK,
      EMIT,
      ADVANCE,
      FIN
   } state_e;

   typedef struct packed {
      logic [31:0] node;
      logic [31:0] x;
      logic [31:0] y;
      logic        err;
   } tuple_t;

   function automatic logic bad_node(logic signed [31:0] w);
      return (w != EMPTY) && ((w < 32'sd0) || (w >= N_NODES));
   endfunction

endpackage

// File: rtl/placement_tuple_skid.sv
// One-entry output register: loads a tuple, then holds valid and payload
// steady until the consumer takes it.
module placement_tuple_skid
   import placement_reader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic [31:0] node_i,
   input  logic [31:0] x_i,
   input  logic [31:0] y_i,
   input  logic        err_i,
   input  logic        ready_i,
   output logic        valid_o,
   output logic [31:0] node_o,
   output logic [31:0] x_o,
   output logic [31:0] y_o,
   output logic        err_o
);

   tuple_t data_q, data_d;
   logic   valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (load_i) begin
         data_d  = '{node: node_i, x: x_i, y: y_i, err: err_i};
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign valid_o = valid_q;
   assign node_o  = data_q.node;
   assign x_o     = data_q.x;
   assign y_o     = data_q.y;
   assign err_o   = data_q.err;

endmodule

// File: rtl/placement_reader.sv
// Row-major read-back of the grid RAM, cross-checking every occupied cell
// against pos_X/pos_Y and streaming (node, x, y, err) tuples.
module placement_reader
   import placement_reader_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               grid_rd,
   output logic [31:0]        grid_addr,
   input  logic signed [31:0] grid_rdata,
   output logic               pos_rd,
   output logic [31:0]        pos_addr,
   input  logic signed [31:0] posx_rdata,
   input  logic signed [31:0] posy_rdata,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_node,
   output logic [31:0]        out_x,
   output logic [31:0]        out_y,
   output logic               out_err,
   output logic [31:0]        placed_count,
   output logic               error,
   output logic [31:0]        err_cell
);

   localparam logic [31:0] COL_MAX  = 32'(N - 1);
   localparam logic [31:0] CELL_MAX = 32'(CELLS - 1);

   state_e             state_q, state_d;
   logic [31:0]        cell_q, cell_d;
   logic [31:0]        row_q, row_d;
   logic [31:0]        col_q, col_d;
   logic [31:0]        node_q, node_d;
   logic signed [31:0] gword_q, gword_d;
   logic [31:0]        px_q, px_d;
   logic [31:0]        py_q, py_d;
   logic [31:0]        placed_q, placed_d;
   logic               error_q, error_d;
   logic [31:0]        err_cell_q, err_cell_d;

   logic is_empty, bad_id, pos_bad, last, flag_err;
   logic load, load_err;

   assign is_empty = (gword_q == EMPTY);
   assign bad_id   = bad_node(gword_q);
   assign pos_bad  = (px_q != row_q) || (py_q != col_q);
   assign last     = (cell_q == CELL_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (start) state_d = GRID_RD;
         GRID_RD:   state_d = GRID_WAIT;
         GRID_WAIT: state_d = CLASSIFY;
         CLASSIFY: begin
            if (is_empty)    state_d = ADVANCE;
            else if (bad_id) state_d = EMIT;
            else             state_d = POS_RD;
         end
         POS_RD:    state_d = POS_WAIT;
         POS_WAIT:  state_d = CHECK;
         CHECK:     state_d = EMIT;
         EMIT:      if (out_ready) state_d = ADVANCE;
         ADVANCE:   state_d = last ? FIN : GRID_RD;
         FIN:       state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_comb begin
      grid_rd  = (state_q == GRID_RD);
      pos_rd   = (state_q == POS_RD);
      done     = (state_q == FIN);
      busy     = (state_q != IDLE) && (state_q != FIN);
      load     = (state_q == CHECK) ||
                 ((state_q == CLASSIFY) && bad_id);
      load_err = (state_q == CHECK) ? pos_bad : 1'b1;
   end

   always_comb begin
      cell_d     = cell_q;
      row_d      = row_q;
      col_d      = col_q;
      node_d     = node_q;
      gword_d    = gword_q;
      px_d       = px_q;
      py_d       = py_q;
      placed_d   = placed_q;
      error_d    = error_q;
      err_cell_d = err_cell_q;
      flag_err   = 1'b0;
      unique case (1'b1)
         (state_q == IDLE) && start: begin
            cell_d     = '0;
            row_d      = '0;
            col_d      = '0;
            placed_d   = '0;
            error_d    = 1'b0;
            err_cell_d = '0;
         end
         state_q == GRID_WAIT: gword_d = grid_rdata;
         (state_q == CLASSIFY) && !is_empty: begin
            if (bad_id) begin
               flag_err = 1'b1;
            end else begin
               node_d   = gword_q;
               placed_d = placed_q + 32'd1;
            end
         end
         state_q == POS_WAIT: begin
            px_d = posx_rdata;
            py_d = posy_rdata;
         end
         state_q == CHECK: flag_err = pos_bad;
         (state_q == ADVANCE) && !last: begin
            cell_d = cell_q + 32'd1;
            if (col_q == COL_MAX) begin
               col_d = '0;
               row_d = row_q + 32'd1;
            end else begin
               col_d = col_q + 32'd1;
            end
         end
         default: ;
      endcase
      // only the first failing cell of a scan is remembered
      if (flag_err) begin
         error_d = 1'b1;
         if (!error_q) err_cell_d = cell_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cell_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         node_q     <= '0;
         gword_q    <= '0;
         px_q       <= '0;
         py_q       <= '0;
         placed_q   <= '0;
         error_q    <= 1'b0;
         err_cell_q <= '0;
      end else begin
         cell_q     <= cell_d;
         row_q      <= row_d;
         col_q      <= col_d;
         node_q     <= node_d;
         gword_q    <= gword_d;
         px_q       <= px_d;
         py_q       <= py_d;
         placed_q   <= placed_d;
         error_q    <= error_d;
         err_cell_q <= err_cell_d;
      end
   end

   assign grid_addr    = cell_q;
   assign pos_addr     = node_q;
   assign placed_count = placed_q;
   assign error        = error_q;
   assign err_cell     = err_cell_q;

   placement_tuple_skid u_skid (
      .clk_i   (clk),
      .rst_i   (reset),
      .load_i  (load),
      .node_i  (gword_q),
      .x_i     (row_q),
      .y_i     (col_q),
      .err_i   (load_err),
      .ready_i (out_ready),
      .valid_o (out_valid),
      .node_o  (out_node),
      .x_o     (out_x),
      .y_o     (out_y),
      .err_o   (out_err)
   );

endmodule

// File: tb/tb_placement_reader.sv
// Randomised bench for placement_reader: grid/position RAM models plus a
// per-cell reference of the expected tuple stream, status and scan time.
module tb_placement_reader;

   logic               clk = 1'b0;
   logic               reset, start, busy, done;
   logic               grid_rd, pos_rd, out_valid, out_ready;
   logic               out_err, error;
   logic [31:0]        grid_addr, pos_addr, out_node, out_x, out_y;
   logic [31:0]        placed_count, err_cell;
   logic signed [31:0] grid_rdata, posx_rdata, posy_rdata;

   always #5 clk = ~clk;

   placement_reader dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .grid_rd      (grid_rd),
      .grid_addr    (grid_addr),
      .grid_rdata   (grid_rdata),
      .pos_rd       (pos_rd),
      .pos_addr     (pos_addr),
      .posx_rdata   (posx_rdata),
      .posy_rdata   (posy_rdata),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_node     (out_node),
      .out_x        (out_x),
      .out_y        (out_y),
      .out_err      (out_err),
      .placed_count (placed_count),
      .error        (error),
      .err_cell     (err_cell)
   );

   int grid_mem [49];
   int posx_mem [128];
   int posy_mem [128];

   always @(posedge clk) begin
      if (grid_rd && grid_addr < 49) grid_rdata <= grid_mem[grid_addr];
      if (pos_rd && pos_addr < 128) begin
         posx_rdata <= posx_mem[pos_addr];
         posy_rdata <= posy_mem[pos_addr];
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   logic [127:0] pay;
   assign pay = {out_node, out_x, out_y, 31'b0, out_err};

   int           cyc = 0, start_cyc = -10, done_cyc = 0;
   int           n_grd, n_prd, n_done, n_stall, n_unstable;
   logic         busy_after, prev_stall = 1'b0;
   logic [127:0] prev_pay;
   logic [127:0] got_q [$];

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (start && !busy) start_cyc = cyc;
         if (cyc == start_cyc + 1) busy_after = busy;
         if (grid_rd) n_grd++;
         if (pos_rd) n_prd++;
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (prev_stall && (!out_valid || pay != prev_pay)) n_unstable++;
         if (out_valid && out_ready) got_q.push_back(pay);
         if (out_valid && !out_ready) n_stall++;
         prev_stall = out_valid && !out_ready;
         prev_pay   = pay;
      end
   end

   logic [127:0] exp_q [$];
   int           exp_placed, exp_err_cell, exp_base;
   logic         exp_error;
   int           stall_seen;

   task automatic clear_mem();
      foreach (grid_mem[c]) grid_mem[c] = -1;
      foreach (posx_mem[n]) begin
         posx_mem[n] = 0;
         posy_mem[n] = 0;
      end
   endtask

   // cell c sits at x = c / N, y = c % N; cost in cycles per cell kind
   task automatic build_model();
      int   g, x, y;
      logic e;
      exp_q.delete();
      exp_placed   = 0;
      exp_error    = 1'b0;
      exp_err_cell = 0;
      exp_base     = 2;
      for (int c = 0; c < 49; c++) begin
         g = grid_mem[c];
         x = c / 7;
         y = c % 7;
         if (g == -1) begin
            exp_base += 4;
            continue;
         end
         if (g < 0 || g >= 128) begin
            e = 1'b1;
            exp_base += 5;
         end else begin
            e = (posx_mem[g] != x) || (posy_mem[g] != y);
            exp_base += 8;
            exp_placed++;
         end
         if (e && !exp_error) begin
            exp_error    = 1'b1;
            exp_err_cell = c;
         end
         exp_q.push_back({32'(g), 32'(x), 32'(y), 31'b0, e});
      end
   endtask

   task automatic start_scan();
      got_q.delete();
      n_grd      = 0;
      n_prd      = 0;
      n_done     = 0;
      n_stall    = 0;
      n_unstable = 0;
      busy_after = 1'b0;
      stall_seen = 0;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // mode 0: ready high, 1: random ready, 2: first beat stalled 5 cycles,
   // 3: return while beat 20 is on the bus
   task automatic wait_done(input int mode, input int restart_at);
      int nb = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         start = (i == restart_at);
         case (mode)
            1:       out_ready = ($urandom_range(0, 2) != 0);
            2:       out_ready = (stall_seen >= 5);
            default: out_ready = 1'b1;
         endcase
         @(negedge clk);
         if (mode == 2 && out_valid && !out_ready) stall_seen++;
         if (out_valid && out_ready) nb++;
         if (mode == 3 && nb == 20) return;
         if (done) return;
      end
      chk("timeout", 1, 0);
   endtask

   task automatic check_scan();
      @(negedge clk);
      chk("beats", got_q.size(), exp_q.size());
      foreach (exp_q[k])
         if (k < got_q.size()) chk("beat", got_q[k], exp_q[k]);
      chk("placed", placed_count, exp_placed);
      chk("error", error, exp_error);
      chk("err_cell", err_cell, exp_err_cell);
      chk("grid_rds", n_grd, 49);
      chk("pos_rds", n_prd, exp_placed);
      chk("latency", done_cyc - start_cyc + 1, exp_base + n_stall);
      chk("done_cnt", n_done, 1);
      chk("busy_rise", busy_after, 1);
      chk("stable", n_unstable, 0);
      chk("idle", busy, 0);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      out_ready = 1'b1;
      clear_mem();
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_grd", grid_rd, 0);
      chk("rst_prd", pos_rd, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_pay", pay, 0);
      chk("rst_status", {error, placed_count, err_cell}, 0);
      chk("rst_addr", {grid_addr, pos_addr}, 0);
      reset = 1'b0;

      // empty grid, plus a start pulse while busy that must be ignored
      build_model();
      chk("empty_lat_model", exp_base, 198);
      start_scan();
      wait_done(0, 40);
      check_scan();

      clear_mem();
      grid_mem[10] = 5;
      posx_mem[5]  = 1;
      posy_mem[5]  = 3;
      build_model();
      start_scan();
      wait_done(0, -1);
      check_scan();

      start_scan();
      wait_done(2, -1);
      chk("stall_cycles", stall_seen, 5);
      check_scan();

      posx_mem[5]  = 2;
      grid_mem[20] = 6;
      posx_mem[6]  = 0;
      posy_mem[6]  = 6;
      build_model();
      start_scan();
      wait_done(0, -1);
      check_scan();

      clear_mem();
      grid_mem[3] = 200;
      build_model();
      start_scan();
      wait_done(0, -1);
      check_scan();

      clear_mem();
      for (int c = 0; c < 49; c++) begin
         grid_mem[c] = c;
         posx_mem[c] = c / 7;
         posy_mem[c] = c % 7;
      end
      build_model();
      start_scan();
      wait_done(3, -1);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_placed", placed_count, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      start_scan();
      wait_done(0, -1);
      check_scan();

      for (int t = 0; t < 3; t++) begin
         int r, n;
         clear_mem();
         for (int c = 0; c < 49; c++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
               grid_mem[c] = -1;
            end else if (r == 4) begin
               if ($urandom_range(0, 1) == 1)
                  grid_mem[c] = 128 + int'($urandom_range(0, 1000));
               else
                  grid_mem[c] = -2 - int'($urandom_range(0, 100));
            end else begin
               n = $urandom_range(0, 127);
               grid_mem[c] = n;
               posx_mem[n] = c / 7 + (($urandom_range(0, 4) == 0) ? 1 : 0);
               posy_mem[n] = c % 7;
            end
         end
         build_model();
         start_scan();
         wait_done(1, -1);
         check_scan();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
